// File: rtl/input_loop_ctrl.sv
// -----------------------------------------------------------------------------
// input_loop_ctrl
//
// Sequencer for a Tn-lane multiply/add-tree datapath. For one output pixel it
// walks the input channels in chunks of Tn_p (ti = 0, Tn_p, 2*Tn_p, ... < n).
// For each chunk it pulses a buffer read, presents the chunk base and a lane
// mask, then captures the datapath sum as the new running accumulator. The
// running accumulator is fed back to the datapath as its initial value, and
// the final sum is returned to the consumer over a valid/ready handshake.
//
// Optional build macro:
//   INPUT_LOOP_CTRL_RELU_EN  - clamp negative final sums to 0.0 on result_o.
//                              The fed-back accumulator is never clamped.
//
// Ports:
//   clk_i           clock
//   reset_n_i       synchronous active-low reset
//   start_i         request one output pixel (accepted when start_i & ready_o)
//   ready_o         controller idle
//   n_i             input channel count, sampled on accept (clamped to N_max_p)
//   bias_i          initial accumulator value, sampled on accept
//   rd_en_o         buffer read strobe for the chunk at chan_base_o
//   chan_base_o     first channel index of the current chunk
//   lane_en_o       per-lane enable; lane k active iff chan_base_o+k < n
//   fm_init_o       running accumulator, initial value for the datapath
//   fm_sum_i        datapath output (lane products + fm_init_o)
//   done_o          result valid
//   result_o        final pixel sum
//   result_ready_i  consumer accepts result
// -----------------------------------------------------------------------------
module input_loop_ctrl #(
  parameter int Tn_p    = 2,
  parameter int N_max_p = 64,
  parameter int AW_p    = $clog2(N_max_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  output logic                         ready_o,
  input  logic [$clog2(N_max_p+1)-1:0] n_i,
  input  shortreal                     bias_i,
  output logic                         rd_en_o,
  output logic [AW_p-1:0]              chan_base_o,
  output logic [Tn_p-1:0]              lane_en_o,
  output shortreal                     fm_init_o,
  input  shortreal                     fm_sum_i,
  output logic                         done_o,
  output shortreal                     result_o,
  input  logic                         result_ready_i
);

  localparam int NW_p = $clog2(N_max_p+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NW_p-1:0] r_n;
  logic [AW_p-1:0] r_ti;
  shortreal        r_acc;

  logic [NW_p-1:0] w_n_clamp;
  logic            w_last;
  logic [Tn_p-1:0] w_mask;
  shortreal        w_result;

  // Lane k is live while ti+k is still below the channel count; evaluated in
  // 32 bits so ti+k can never wrap the narrow address width.
  function automatic logic [Tn_p-1:0] lane_mask(input logic [31:0] ti,
                                                input logic [31:0] n);
    logic [Tn_p-1:0] m;
    m = '0;
    for (int k = 0; k < Tn_p; k++) begin
      m[k] = ((ti + 32'(k)) < n);
    end
    return m;
  endfunction

  function automatic shortreal relu(input shortreal x);
    return (x < 0.0) ? 0.0 : x;
  endfunction

  // A request larger than the buffer depth is clamped rather than wrapped.
  assign w_n_clamp = (32'(n_i) > 32'(N_max_p)) ? NW_p'(N_max_p) : n_i;

  // Current chunk is the last one once the next base would reach n.
  assign w_last = ((32'(r_ti) + 32'(Tn_p)) >= 32'(r_n));
  assign w_mask = lane_mask(32'(r_ti), 32'(r_n));

`ifdef INPUT_LOOP_CTRL_RELU_EN
  assign w_result = relu(r_acc);
`else
  assign w_result = r_acc;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    rd_en_o     = 1'b0;
    done_o      = 1'b0;
    lane_en_o   = '0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          w_state_nxt = (w_n_clamp != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        rd_en_o     = 1'b1;
        lane_en_o   = w_mask;
        w_state_nxt = S_ACC;
      end
      S_ACC: begin
        // Mask stays up so the datapath zeroes the same lanes while summing.
        lane_en_o   = w_mask;
        w_state_nxt = w_last ? S_DONE : S_READ;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (result_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Loop counters and accumulator
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_n   <= '0;
      r_ti  <= '0;
      r_acc <= 0.0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_n   <= w_n_clamp;
            r_ti  <= '0;
            r_acc <= bias_i;
          end
        end
        S_ACC: begin
          r_acc <= fm_sum_i;
          // ti only advances while another chunk remains, so it stays < n.
          if (!w_last) begin
            r_ti <= r_ti + AW_p'(Tn_p);
          end
        end
        default: ;
      endcase
    end
  end

  assign chan_base_o = r_ti;
  assign fm_init_o   = r_acc;
  assign result_o    = (r_state == S_DONE) ? w_result : 0.0;

endmodule

// File: doc/input_loop_ctrl.md
Name: input_loop_ctrl

Overview:
- Sequencer for the Tn-wide multiply/add-tree datapath.
- For one output pixel, walks input channels ti = 0, Tn, 2Tn, ... < N, issuing buffer reads and lane masks for each chunk.
- Feeds back the running partial sum as the datapath's initial value, and returns the final sum over a valid/ready handshake.
- Sits between the tile scheduler (output-pixel loop) and the input/weight buffers plus the adder tree.

Parameters:
- Tn_p, 2, lanes in the datapath (channels per chunk), >=1
- N_max_p, 64, maximum input channels per pixel; sets address width
- AW_p, $clog2(N_max_p), width of the channel address

Ports:
- clk_i  input  1  clock
- reset_n_i  input  1  synchronous active-low reset
- start_i  input  1  request to compute one output pixel
- ready_o  output  1  controller idle; start accepted when start_i & ready_o
- n_i  input  $clog2(N_max_p+1)  input channel count, sampled on accept
- bias_i  input  shortreal  initial accumulator value, sampled on accept
- rd_en_o  output  1  buffer read strobe for chunk at chan_base_o
- chan_base_o  output  AW_p  first channel index ti of current chunk
- lane_en_o  output  Tn_p  lane k active iff ti+k < n; datapath zeroes inactive lanes
- fm_init_o  output  shortreal  running accumulator, drives datapath fm_init
- fm_sum_i  input  shortreal  datapath output (sum of lane products + fm_init_o)
- done_o  output  1  result valid
- result_o  output  shortreal  final pixel sum
- result_ready_i  input  1  consumer accepts result

Behaviour:
- Reset (clk edge with reset_n_i=0, any state, including mid-operation):
  - State returns to IDLE.
  - ready_o=1; rd_en_o=0, chan_base_o=0, lane_en_o=0, done_o=0.
  - Accumulator and result_o cleared to 0.0.
- States: IDLE, READ, ACC, DONE.
- IDLE:
  - ready_o=1.
  - On accept, latch n = min(n_i, N_max_p); acc <= bias_i; ti <= 0.
  - Next state is READ if n>0, else DONE.
- READ (1 cycle):
  - rd_en_o=1, chan_base_o=ti, lane_en_o per mask.
  - Buffers return data on the next cycle.
- ACC (1 cycle):
  - rd_en_o=0; chan_base_o and lane_en_o held.
  - acc <= fm_sum_i.
  - If ti+Tn_p >= n, go to DONE; else ti <= ti+Tn_p and go to READ.
- DONE:
  - done_o=1, result_o=acc.
  - Outputs held stable while result_ready_i=0.
  - On done_o & result_ready_i, go to IDLE.
- Outputs outside their active states: lane_en_o=0 in IDLE/DONE. fm_init_o=acc at all times.
- ready_o is 0 in READ/ACC/DONE. start_i there is ignored; nothing is queued.
- Latency: chunks C=ceil(n/Tn_p). With accept at cycle 0, done_o rises at cycle 2C+1; for n=0, done_o rises at cycle 1.
- Tail chunk: lane_en_o[k]=0 for ti+k >= n, e.g. Tn_p=2, n=3, second chunk gives 2'b01.
- ti never exceeds n-1. No address wrap, since n <= N_max_p.
- Back-to-back operation: an accept in IDLE the cycle after DONE handshake is allowed; there is no idle bubble requirement.

Optional Feature:
- Macro INPUT_LOOP_CTRL_RELU_EN.
- Defined: result_o = (acc < 0.0) ? 0.0 : acc in DONE. fm_init_o is unaffected (ReLU is applied only to the final sum). Latency unchanged.
- Undefined: result_o = acc unmodified.

Test Plan:
- Tn_p=2, n=2, bias=0, fm{20,5}, w{10,10}:
  - One READ/ACC pair, lane_en_o=2'b11, chan_base_o=0.
  - result_o=250.0 with done_o at cycle 3.
- Same data, bias=1.54: result_o=251.54.
- n=3, bias=0, fm{1.72,7.2,2}, w{5,0,3}:
  - Chunks at chan_base 0 then 2; lane_en 2'b11 then 2'b01.
  - result_o=14.6 at cycle 5.
- n=0, bias=3.0: no rd_en_o pulses; done_o at cycle 1, result_o=3.0.
- Backpressure and ignored start:
  - result_ready_i=0 for 4 cycles in DONE: result_o/done_o stable, ready_o=0, start_i pulses ignored.
  - Release: IDLE next cycle.
- Reset and ReLU:
  - reset_n_i=0 during ACC of n=4 job: next cycle IDLE, all outputs at reset values.
  - With INPUT_LOOP_CTRL_RELU_EN and sum -7.5: result_o=0.0.
